// File: rtl/simon_cipher_encrypt.sv
// Iterative Simon 32/64 encryption core. Round keys are expanded on the fly, one step per round.
// Optional SIMON_ENCRYPT_DUAL_ROUND_EN: two chained rounds per cycle (16-cycle latency).
module simon_cipher_encrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] plntxt,
    input  logic [63:0] key,
    input  logic        start_cipher,
    input  logic        cphrtxt_ack,
    output logic        ready,
    output logic        cphrtxt_rdy,
    output logic [31:0] cphrtxt
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Sequence digit i is stored at bit i, so the leftmost digit lands in bit 0.
    localparam logic [31:0] Z0_SEQ = 32'hB386_A45F;

    function automatic logic [15:0] rol1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    function automatic logic [15:0] rol2(input logic [15:0] v);
        return {v[13:0], v[15:14]};
    endfunction

    function automatic logic [15:0] rol8(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] ror1(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] v);
        return {v[2:0], v[15:3]};
    endfunction

    function automatic logic [15:0] simon_f(input logic [15:0] v);
        return (rol1(v) & rol8(v)) ^ rol2(v);
    endfunction

    function automatic logic [15:0] key_step(input logic [15:0] k0, input logic [15:0] k1,
                                             input logic [15:0] k3, input logic zbit);
        logic [15:0] t;
        t = ror3(k3) ^ k1;
        return ~k0 ^ t ^ ror1(t) ^ {15'd0, zbit} ^ 16'h0003;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_k0;
    logic [15:0] r_k1;
    logic [15:0] r_k2;
    logic [15:0] r_k3;
    logic [4:0]  r_rnd;
    logic        r_ready;
    logic        r_cphrtxt_rdy;
    logic [31:0] r_cphrtxt;

    logic [15:0] w_x1;
    logic [15:0] w_kn1;
    logic [15:0] w_x_nxt;
    logic [15:0] w_y_nxt;
    logic [15:0] w_k0_nxt;
    logic [15:0] w_k1_nxt;
    logic [15:0] w_k2_nxt;
    logic [15:0] w_k3_nxt;
    logic [4:0]  w_rnd_nxt;
    logic        w_last;
`ifdef SIMON_ENCRYPT_DUAL_ROUND_EN
    logic [15:0] w_kn2;
`endif

    // Round function and key-schedule step(s) performed during one RUN cycle
    always_comb begin
        w_x1  = r_y ^ simon_f(r_x) ^ r_k0;
        w_kn1 = key_step(r_k0, r_k1, r_k3, Z0_SEQ[r_rnd]);
`ifdef SIMON_ENCRYPT_DUAL_ROUND_EN
        // Second round sees y = r_x (first round's y') and uses the next key word r_k1.
        w_kn2     = key_step(r_k1, r_k2, w_kn1, Z0_SEQ[r_rnd + 5'd1]);
        w_x_nxt   = r_x ^ simon_f(w_x1) ^ r_k1;
        w_y_nxt   = w_x1;
        w_k0_nxt  = r_k2;
        w_k1_nxt  = r_k3;
        w_k2_nxt  = w_kn1;
        w_k3_nxt  = w_kn2;
        w_rnd_nxt = r_rnd + 5'd2;
        w_last    = (r_rnd == 5'd30);
`else
        w_x_nxt   = w_x1;
        w_y_nxt   = r_x;
        w_k0_nxt  = r_k1;
        w_k1_nxt  = r_k2;
        w_k2_nxt  = r_k3;
        w_k3_nxt  = w_kn1;
        w_rnd_nxt = r_rnd + 5'd1;
        w_last    = (r_rnd == 5'd31);
`endif
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_cipher) w_state_nxt = ST_RUN;
                else              w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (cphrtxt_ack) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_x           <= 16'h0000;
            r_y           <= 16'h0000;
            r_k0          <= 16'h0000;
            r_k1          <= 16'h0000;
            r_k2          <= 16'h0000;
            r_k3          <= 16'h0000;
            r_rnd         <= 5'd0;
            r_ready       <= 1'b1;
            r_cphrtxt_rdy <= 1'b0;
            r_cphrtxt     <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start_cipher) begin
                        r_x   <= plntxt[31:16];
                        r_y   <= plntxt[15:0];
                        r_k0  <= key[15:0];
                        r_k1  <= key[31:16];
                        r_k2  <= key[47:32];
                        r_k3  <= key[63:48];
                        r_rnd <= 5'd0;
                    end
                end
                ST_RUN: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_k0  <= w_k0_nxt;
                    r_k1  <= w_k1_nxt;
                    r_k2  <= w_k2_nxt;
                    r_k3  <= w_k3_nxt;
                    r_rnd <= w_rnd_nxt;
                    if (w_last) begin
                        r_cphrtxt     <= {w_x_nxt, w_y_nxt};
                        r_cphrtxt_rdy <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (cphrtxt_ack) r_cphrtxt_rdy <= 1'b0;
                end
                default: r_cphrtxt_rdy <= 1'b0;
            endcase
        end
    end

    assign ready       = r_ready;
    assign cphrtxt_rdy = r_cphrtxt_rdy;
    assign cphrtxt     = r_cphrtxt;
endmodule

// File: tb/tb_simon_cipher_encrypt.sv
// Scoreboard bench for simon_cipher_encrypt: published vector, backpressure, ignored start,
// mid-run reset and a randomised round trip through a reference decryptor.
module tb_simon_cipher_encrypt;
`ifdef SIMON_ENCRYPT_DUAL_ROUND_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 32;
`endif
    localparam logic [63:0] PUB_KEY = 64'h1918111009080100;
    localparam logic [31:0] PUB_PT  = 32'h65656877;
    localparam logic [31:0] PUB_CT  = 32'hc69be9bb;
    localparam logic [0:31] Z0_TB   = 32'b11111010001001010110000111001101;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_cipher = 1'b0;
    logic        cphrtxt_ack = 1'b0;
    logic [31:0] plntxt = 32'h0;
    logic [63:0] key = 64'h0;
    logic        ready;
    logic        cphrtxt_rdy;
    logic [31:0] cphrtxt;

    simon_cipher_encrypt dut (
        .clk(clk), .rst(rst), .plntxt(plntxt), .key(key),
        .start_cipher(start_cipher), .cphrtxt_ack(cphrtxt_ack),
        .ready(ready), .cphrtxt_rdy(cphrtxt_rdy), .cphrtxt(cphrtxt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] k;
        logic [31:0] p;
        bit          has_exp;
        logic [31:0] exp;
        int          acc;
    } sb_t;
    sb_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v};
        return d[31-n -: 16];
    endfunction

    function automatic logic [15:0] fr(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    // Reference decryption: full key expansion, then rounds undone in reverse order.
    function automatic logic [31:0] decrypt(input logic [63:0] k, input logic [31:0] c);
        logic [15:0] ks [32];
        logic [15:0] t, x, y, nx, ny;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t = rotl(ks[i+3], 13) ^ ks[i+1];
            t = t ^ rotl(t, 15);
            ks[i+4] = ks[i] ^ 16'hfffc ^ t ^ {15'd0, Z0_TB[i]};
        end
        x = c[31:16];
        y = c[15:0];
        for (int i = 31; i >= 0; i--) begin
            nx = y;
            ny = x ^ fr(y) ^ ks[i];
            x = nx;
            y = ny;
        end
        return {x, y};
    endfunction

    // Monitor: one scoreboard pop per cphrtxt_rdy assertion.
    bit mon_taken = 1'b0;
    always @(negedge clk) begin
        sb_t e;
        if (cphrtxt_rdy && !mon_taken) begin
            mon_taken = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(cphrtxt_rdy), 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.has_exp) check("ciphertext", 64'(cphrtxt), 64'(e.exp));
                check("roundtrip", 64'(decrypt(e.k, cphrtxt)), 64'(e.p));
                check("latency", 64'(cyc - e.acc), 64'(LAT));
            end
        end else if (!cphrtxt_rdy) begin
            mon_taken = 1'b0;
        end
    end

    task automatic issue(input logic [63:0] k, input logic [31:0] p, input bit has_exp,
                         input logic [31:0] exp);
        sb_t e;
        for (int w = 0; w < 200 && !ready; w++) @(negedge clk);
        check("ready_before_issue", 64'(ready), 64'd1);
        key = k;
        plntxt = p;
        start_cipher = 1'b1;
        @(posedge clk);
        #1;
        e.k = k; e.p = p; e.has_exp = has_exp; e.exp = exp; e.acc = cyc;
        sb.push_back(e);
        start_cipher = 1'b0;
    endtask

    task automatic wait_done(input int inj_start, input int inj_rst, input int hold);
        bit got;
        got = 1'b0;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (c == inj_start + 1) start_cipher = 1'b0;
            if (cphrtxt_rdy) begin
                got = 1'b1;
                break;
            end
            check("ready_low_in_run", 64'(ready), 64'd0);
            if (c == inj_start) begin
                start_cipher = 1'b1;
                plntxt = 32'h0000_0000;
            end
            if (c == inj_rst) begin
                rst = 1'b0;
                sb.delete(sb.size() - 1);
                @(negedge clk);
                rst = 1'b1;
                check("midrst_ready", 64'(ready), 64'd1);
                check("midrst_rdy", 64'(cphrtxt_rdy), 64'd0);
                check("midrst_ct", 64'(cphrtxt), 64'd0);
                return;
            end
        end
        if (!got) check("result_timeout", 64'(cphrtxt_rdy), 64'd1);
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_rdy", 64'(cphrtxt_rdy), 64'd1);
                check("hold_ct", 64'(cphrtxt), 64'(PUB_CT));
            end
            cphrtxt_ack = 1'b1;
            @(posedge clk);
            #1;
            cphrtxt_ack = 1'b0;
            @(negedge clk);
            check("ack_rdy_low", 64'(cphrtxt_rdy), 64'd0);
            check("ack_ready_high", 64'(ready), 64'd1);
        end
    endtask

    initial begin
        int extra;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_rdy", 64'(cphrtxt_rdy), 64'd0);
        check("reset_ct", 64'(cphrtxt), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Published vector with 20 cycles of backpressure
        issue(PUB_KEY, PUB_PT, 1'b1, PUB_CT);
        wait_done(-1, -1, 20);

        // start_cipher during RUN must be dropped
        issue(PUB_KEY, PUB_PT, 1'b1, PUB_CT);
        wait_done(10, -1, 0);
        extra = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (cphrtxt_rdy) extra++;
        end
        check("no_second_result", 64'(extra), 64'd0);

        // Reset in the middle of RUN, then a clean run
        issue(PUB_KEY, PUB_PT, 1'b1, PUB_CT);
        wait_done(-1, 15, 0);
        issue(PUB_KEY, PUB_PT, 1'b1, PUB_CT);
        wait_done(-1, -1, 0);

        // Random round trip, back-to-back at the minimum gap
        for (int i = 0; i < 100; i++) begin
            issue({$urandom, $urandom}, $urandom, 1'b0, 32'h0);
            wait_done(-1, -1, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
